seq_divider: RTL



---
 rtl/seq_divider_if.sv | 30 +++
 rtl/seq_divider.sv | 112 +++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider; div_err exists only with SEQ_DIVIDER_DIV_ZERO_ERR_EN.
// Combinational wiring only, no latency; start is ignored while busy and the result is not in DONE.
interface seq_divider_if;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
`ifdef SEQ_DIVIDER_DIV_ZERO_ERR_EN
  logic        div_err;
`endif

  modport master (
    output start, dividend, divisor,
`ifdef SEQ_DIVIDER_DIV_ZERO_ERR_EN
    input  div_err,
`endif
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
`ifdef SEQ_DIVIDER_DIV_ZERO_ERR_EN
    output div_err,
`endif
    output busy, done, quotient, remainder
  );
endinterface

// File: rtl/seq_divider.sv
// 16/8 unsigned restoring divider, one quotient bit per clock; SEQ_DIVIDER_DIV_ZERO_ERR_EN adds div_err.
// Latency 16 cycles from the accepting edge to the done pulse; one result per 17 cycles.
// Backpressure: start is dropped (not queued) while RUN; a start during DONE is accepted back-to-back.
module seq_divider (
  input  logic       clk,
  input  logic       rst_n,
  seq_divider_if.slave div_if
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q;
  logic [15:0] q_q;
  logic [7:0]  r_q;      // partial remainder; always < divisor once past the compare, so 8 bits hold it
  logic [7:0]  dvsr_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] quot_q;
  logic [7:0]  rem_q;
`ifdef SEQ_DIVIDER_DIV_ZERO_ERR_EN
  logic        err_q;
`else
  logic [7:0]  dvd_lo_q;
`endif

  logic [8:0]  r_shift_d;
  logic        fits_d;
  logic [7:0]  r_d;
  logic [15:0] q_d;
  logic        accept_d;

  always_comb begin
    r_shift_d = {r_q, q_q[15]};
    fits_d    = (r_shift_d >= {1'b0, dvsr_q});
    r_d       = fits_d ? 8'(r_shift_d - {1'b0, dvsr_q}) : r_shift_d[7:0];
    q_d       = {q_q[14:0], fits_d};
    accept_d  = div_if.start && (state_q != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      q_q      <= '0;
      r_q      <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
`ifdef SEQ_DIVIDER_DIV_ZERO_ERR_EN
      err_q    <= 1'b0;
`else
      dvd_lo_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept_d) begin
        state_q  <= RUN;
        busy_q   <= 1'b1;
        q_q      <= div_if.dividend;
        dvsr_q   <= div_if.divisor;
        r_q      <= '0;
        cnt_q    <= '0;
`ifdef SEQ_DIVIDER_DIV_ZERO_ERR_EN
        err_q    <= 1'b0;
`else
        dvd_lo_q <= div_if.dividend[7:0];
`endif
      end else begin
        unique case (state_q)
          RUN: begin
            q_q   <= q_d;
            r_q   <= r_d;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              // Divide-by-zero result is pinned here rather than trusted to the datapath
              if (dvsr_q == 8'd0) begin
`ifdef SEQ_DIVIDER_DIV_ZERO_ERR_EN
                quot_q <= '0;
                rem_q  <= '0;
                err_q  <= 1'b1;
`else
                quot_q <= 16'hFFFF;
                rem_q  <= dvd_lo_q;
`endif
              end else begin
                quot_q <= q_d;
                rem_q  <= r_d;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign div_if.busy      = busy_q;
  assign div_if.done      = done_q;
  assign div_if.quotient  = quot_q;
  assign div_if.remainder = rem_q;
`ifdef SEQ_DIVIDER_DIV_ZERO_ERR_EN
  assign div_if.div_err   = err_q;
`endif
endmodule
